// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] DEF_PATTERN = 4'b1100;
    localparam int         REP_W       = 8;

    // A request for zero repetitions still sends one pattern; the counter holds reps-1.
    function automatic logic [REP_W-1:0] rep_load_val(input logic [REP_W-1:0] reps);
        return (reps == '0) ? '0 : reps - REP_W'(1);
    endfunction

endpackage

// File: rtl/seq_tx_downcnt.sv
// Loadable down-counter with zero flag; cnt_next exposes the value the counter takes at the next edge.
module seq_tx_downcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt_next,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    assign cnt_next = cnt_d;
    assign zero     = (cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Moore serial pattern transmitter: PATTERN MSB-first, then gap_len zero bits, then a done pulse.
// Optional repetition per frame is enabled by defining SEQ_TX_REPEAT_EN.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_TX_REPEAT_EN
    input  logic [REP_W-1:0] rep_cnt,
`endif
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(PAT_W);

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             start_ready_q, start_ready_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_load, bit_dec, bit_zero;
    logic [IW-1:0]    bit_next;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_next_unused;
    logic             reps_left;

    seq_tx_downcnt #(.W(IW)) u_bit_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val (IW'(PAT_W - 1)),
        .dec      (bit_dec),
        .cnt_next (bit_next),
        .zero     (bit_zero)
    );

    // Gap counter holds gap-1 so its zero flag marks the final gap bit.
    seq_tx_downcnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_len_q - GAP_W'(1)),
        .dec      (gap_dec),
        .cnt_next (gap_next_unused),
        .zero     (gap_zero)
    );

`ifdef SEQ_TX_REPEAT_EN
    logic             rep_load, rep_dec, rep_zero;
    logic [REP_W-1:0] rep_next_unused;

    seq_tx_downcnt #(.W(REP_W)) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rep_load),
        .load_val (rep_load_val(rep_cnt)),
        .dec      (rep_dec),
        .cnt_next (rep_next_unused),
        .zero     (rep_zero)
    );

    assign reps_left = !rep_zero;
`else
    assign reps_left = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gap_len_d = gap_len_q;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    gap_len_d = gap_len;
                    bit_load  = 1'b1;
`ifdef SEQ_TX_REPEAT_EN
                    rep_load  = 1'b1;
`endif
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (gap_len_q != '0) begin
                    gap_load = 1'b1;
                    state_d  = GAP;
                end else if (reps_left) begin
                    bit_load = 1'b1;
`ifdef SEQ_TX_REPEAT_EN
                    rep_dec  = 1'b1;
`endif
                end else begin
                    state_d = DONE;
                end
            end
            GAP: begin
                if (!gap_zero) begin
                    gap_dec = 1'b1;
                end else if (reps_left) begin
                    bit_load = 1'b1;
`ifdef SEQ_TX_REPEAT_EN
                    rep_dec  = 1'b1;
`endif
                    state_d  = SEND;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next state so the registered copies line up with state_q.
        start_ready_d = (state_d == IDLE);
        bit_valid_d   = (state_d == SEND) || (state_d == GAP);
        busy_d        = bit_valid_d;
        bit_out_d     = (state_d == SEND) && PATTERN[bit_next];
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            gap_len_q     <= '0;
            start_ready_q <= 1'b1;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_len_q     <= gap_len_d;
            start_ready_q <= start_ready_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign start_ready = start_ready_q;
    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: expected serial bits are queued at request time and popped per valid bit.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] gap_len;
`ifdef SEQ_TX_REPEAT_EN
    logic [7:0] rep_cnt;
`endif
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       done;

    int   checks    = 0;
    int   failures  = 0;
    int   valid_cnt = 0;
    int   done_cnt  = 0;
    int   z_cnt     = 0;
    logic [3:0] det_sh = 4'b0000;
    bit   exp_q[$];

    seq_pattern_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .gap_len     (gap_len),
`ifdef SEQ_TX_REPEAT_EN
        .rep_cnt     (rep_cnt),
`endif
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side plus a behavioural 1100 Moore detector fed on bit_valid.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (done === 1'b1) done_cnt++;
            if (bit_valid === 1'b1) begin
                valid_cnt++;
                det_sh = {det_sh[2:0], bit_out};
                if (det_sh == 4'b1100) z_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_bit observed=%b expected=no_bit", bit_out);
                end else begin
                    chk_b("bit_out", bit_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_pattern(input int gap);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int k = 0; k < gap; k++) exp_q.push_back(1'b0);
    endtask

    // One-cycle request, then per-cycle busy/done/ready checks across the whole frame.
    task automatic run_frame(input int gap, input int reps);
        int reps_eff;
        int n;
        reps_eff = (reps == 0) ? 1 : reps;
        n = reps_eff * (4 + gap);
        for (int r = 0; r < reps_eff; r++) push_pattern(gap);
        @(negedge clk);
        start_valid = 1'b1;
        gap_len     = 4'(gap);
`ifdef SEQ_TX_REPEAT_EN
        rep_cnt     = 8'(reps);
`endif
        @(negedge clk);
        start_valid = 1'b0;
        for (int i = 0; i <= n + 1; i++) begin
            if (i > 0) @(negedge clk);
            chk_b($sformatf("valid g%0d i%0d", gap, i), bit_valid, i < n);
            chk_b($sformatf("busy g%0d i%0d", gap, i), busy, i < n);
            chk_b($sformatf("done g%0d i%0d", gap, i), done, i == n);
            chk_b($sformatf("ready g%0d i%0d", gap, i), start_ready, i == n + 1);
        end
        chk_i($sformatf("drain g%0d", gap), exp_q.size(), 0);
    endtask

    initial begin
        int done_snap;
        int valid_snap;
        int z_snap;

        rst         = 1'b1;
        start_valid = 1'b0;
        gap_len     = 4'd0;
`ifdef SEQ_TX_REPEAT_EN
        rep_cnt     = 8'd1;
`endif
        #2;
        chk_b("rst start_ready", start_ready, 1'b1);
        chk_b("rst bit_out", bit_out, 1'b0);
        chk_b("rst bit_valid", bit_valid, 1'b0);
        chk_b("rst busy", busy, 1'b0);
        chk_b("rst done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_b("idle ready", start_ready, 1'b1);

        run_frame(0, 1);
        run_frame(3, 1);
        run_frame(15, 1);

        // start_valid held: frames every 6 cycles with 2 idle cycles between patterns.
        for (int f = 0; f < 3; f++) push_pattern(0);
        @(negedge clk);
        start_valid = 1'b1;
        gap_len     = 4'd0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk_b($sformatf("b2b valid i%0d", i), bit_valid, (i % 6) < 4);
            chk_b($sformatf("b2b done i%0d", i), done, (i % 6) == 4);
            chk_b($sformatf("b2b ready i%0d", i), start_ready, (i % 6) == 5);
            if (i == 12) start_valid = 1'b0;
        end
        chk_i("b2b drain", exp_q.size(), 0);

        // Reset during the third pattern bit drops the frame without a done pulse.
        push_pattern(0);
        @(negedge clk);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_b("midrst bit_valid", bit_valid, 1'b0);
        chk_b("midrst bit_out", bit_out, 1'b0);
        chk_b("midrst start_ready", start_ready, 1'b1);
        chk_b("midrst busy", busy, 1'b0);
        chk_b("midrst done", done, 1'b0);
        chk_i("midrst bits left", exp_q.size(), 1);
        exp_q.delete();
        done_snap = done_cnt;
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_b($sformatf("postrst valid i%0d", i), bit_valid, 1'b0);
        end
        chk_i("postrst no done", done_cnt - done_snap, 0);

        // Requests and gap_len changes during SEND are ignored; the latched gap of 2 is used.
        push_pattern(2);
        valid_snap = valid_cnt;
        @(negedge clk);
        start_valid = 1'b1;
        gap_len     = 4'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) start_valid = 1'b0;
            if (i == 1) begin
                start_valid = 1'b1;
                gap_len     = 4'd5;
            end
            if (i == 3) begin
                start_valid = 1'b0;
                gap_len     = 4'd0;
            end
            chk_b($sformatf("latch valid i%0d", i), bit_valid, i < 6);
            chk_b($sformatf("latch done i%0d", i), done, i == 6);
        end
        chk_i("latch valid count", valid_cnt - valid_snap, 6);
        chk_i("latch drain", exp_q.size(), 0);

`ifdef SEQ_TX_REPEAT_EN
        z_snap = z_cnt;
        run_frame(0, 3);
        chk_i("loopback z rep3", z_cnt - z_snap, 3);
        z_snap = z_cnt;
        run_frame(0, 0);
        chk_i("loopback z rep0", z_cnt - z_snap, 1);
        z_snap = z_cnt;
        run_frame(2, 2);
        chk_i("loopback z rep2 gap2", z_cnt - z_snap, 2);
`else
        z_snap = z_cnt;
        run_frame(0, 1);
        chk_i("loopback z single", z_cnt - z_snap, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
